// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the instruction-cache refill port
//   (read only) and the CPU data port (read/write). Conflicts are resolved
//   round-robin (D_PRIO=0) or always in favour of the data port (D_PRIO=1).
//   Address, write enable and write data are registered at grant; the memory
//   ack and read data are steered back to the granted requester in the same
//   cycle. A watchdog aborts a grant that sees no ack for TIMEOUT cycles.
//
// Ports
//   i_ck, i_rb                 clock (rising edge), async active-low reset
//   i_i_req/i_i_addr           icache request (level) and word address
//   o_i_ack/o_i_data           one-cycle icache ack with read data
//   i_d_req/i_d_we/i_d_addr/
//   i_d_wdata                  data-port request, direction, address, wdata
//   o_d_ack/o_d_data           one-cycle data-port ack with read data
//   o_mem_req/o_mem_we/
//   o_mem_addr/o_mem_wdata     registered memory request
//   i_mem_ack/i_mem_data       memory ack and read data
//   o_timeout                  sticky watchdog-abort flag (reset clears)

module mem_port_arbiter #(
   parameter int unsigned AW      = 30,
   parameter int unsigned DW      = 32,
   parameter int unsigned D_PRIO  = 0,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          i_ck,
   input  logic          i_rb,
   input  logic          i_i_req,
   input  logic [AW-1:0] i_i_addr,
   output logic          o_i_ack,
   output logic [DW-1:0] o_i_data,
   input  logic          i_d_req,
   input  logic          i_d_we,
   input  logic [AW-1:0] i_d_addr,
   input  logic [DW-1:0] i_d_wdata,
   output logic          o_d_ack,
   output logic [DW-1:0] o_d_data,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_data,
   output logic          o_timeout
);

   localparam int unsigned    WDW    = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t         state;
   logic [WDW-1:0] wd_cnt;
   logic           prio_d;     // 1: the data port wins the next conflict
   logic           mask_i;     // turnaround: icache was served last cycle
   logic           mask_d;     // turnaround: data port was served last cycle
   logic           i_elig;
   logic           d_elig;
   logic           pick_d;
   logic           wd_expire;
   logic           done;

   always_comb begin
      i_elig = i_i_req & ~mask_i;
      d_elig = i_d_req & ~mask_d;
      if (i_elig && d_elig)
         pick_d = (D_PRIO != 0) ? 1'b1 : prio_d;
      else
         pick_d = d_elig;

      // A real ack in the expiry cycle wins over the abort.
      wd_expire = (state != IDLE) && (wd_cnt == WD_MAX) && !i_mem_ack;
      done      = (state != IDLE) && (i_mem_ack || wd_expire);

      o_i_ack  = done && (state == GNT_I);
      o_d_ack  = done && (state == GNT_D);
      o_i_data = (o_i_ack && !wd_expire) ? i_mem_data : '0;
      o_d_data = (o_d_ack && !wd_expire) ? i_mem_data : '0;
   end

   always_ff @(posedge i_ck or negedge i_rb) begin
      if (!i_rb) begin
         state       <= IDLE;
         wd_cnt      <= '0;
         prio_d      <= 1'b0;
         mask_i      <= 1'b0;
         mask_d      <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_timeout   <= 1'b0;
      end else begin
         // Masks are live only in the cycle right after a completion.
         mask_i <= o_i_ack;
         mask_d <= o_d_ack;
         case (state)
            IDLE: begin
               if (i_elig || d_elig) begin
                  o_mem_req <= 1'b1;
                  wd_cnt    <= '0;
                  if (pick_d) begin
                     state       <= GNT_D;
                     o_mem_we    <= i_d_we;
                     o_mem_addr  <= i_d_addr;
                     o_mem_wdata <= i_d_wdata;
                     prio_d      <= 1'b0;
                  end else begin
                     state       <= GNT_I;
                     o_mem_we    <= 1'b0;
                     o_mem_addr  <= i_i_addr;
                     o_mem_wdata <= '0;
                     prio_d      <= 1'b1;
                  end
               end
            end
            default: begin
               if (done) begin
                  state     <= IDLE;
                  o_mem_req <= 1'b0;
                  wd_cnt    <= '0;
                  if (wd_expire)
                     o_timeout <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WDW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (round-robin and data
// priority), each with random requesters, a memory responder that also acts
// as the arbitration reference model, and a scoreboard monitor on the acks.

module tb_mem_port_arbiter;

   localparam int AW  = 30;
   localparam int DW  = 32;
   localparam int TO  = 8;
   localparam int NTX = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit done_g [2];

   for (genvar g = 0; g < 2; g++) begin : env
      logic          rst_n;
      logic          i_req, i_ack, d_req, d_we, d_ack;
      logic          mem_req, mem_we, mem_ack, tmo;
      logic [AW-1:0] i_addr, d_addr, mem_addr;
      logic [DW-1:0] i_data, d_data, d_wdata, mem_wdata, mem_data;
      logic [DW:0]   sb [$];   // {port_is_data, expected read data}
      bit            hang_all;

      mem_port_arbiter #(.AW(AW), .DW(DW), .D_PRIO(g), .TIMEOUT(TO)) dut (
         .i_ck(clk), .i_rb(rst_n),
         .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_data(i_data),
         .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
         .o_d_ack(d_ack), .o_d_data(d_data),
         .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
         .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_data(mem_data),
         .o_timeout(tmo)
      );

      // Memory responder + arbitration reference. Requester inputs change at
      // posedge+2, so at posedge+1 they still show the previous cycle's values.
      initial begin : model
         int cyc, cnt, lat, last_done, done_i, done_d, r;
         bit busy, last_d, cur_d, elig_i, elig_d, idle_ok, fin, exp_to;
         cyc = 0; cnt = 0; lat = 0; busy = 0; last_d = 1; cur_d = 0; exp_to = 0;
         last_done = -10; done_i = -10; done_d = -10;
         mem_ack = 1'b0; mem_data = '0;
         forever begin
            @(posedge clk); #1;
            cyc++;
            mem_ack  = 1'b0;
            mem_data = $urandom;
            if (!rst_n) begin
               busy = 0; last_d = 1; exp_to = 0;
               last_done = -10; done_i = -10; done_d = -10;
            end else begin
               if (!busy) begin
                  elig_i  = i_req && (done_i != cyc - 2);
                  elig_d  = d_req && (done_d != cyc - 2);
                  idle_ok = (last_done != cyc - 1);
                  checks++;
                  if (mem_req !== (idle_ok && (elig_i || elig_d))) begin
                     errors++;
                     $display("FAIL g%0d grant_timing cyc %0d: mem_req=%b expected %b",
                              g, cyc, mem_req, idle_ok && (elig_i || elig_d));
                  end else if (mem_req) begin
                     cur_d  = (elig_i && elig_d) ? ((g == 1) ? 1'b1 : !last_d) : elig_d;
                     last_d = cur_d;
                     checks++;
                     if (mem_addr !== (cur_d ? d_addr : i_addr) ||
                         mem_we !== (cur_d ? d_we : 1'b0) ||
                         (cur_d && d_we && mem_wdata !== d_wdata) || tmo !== exp_to) begin
                        errors++;
                        $display("FAIL g%0d grant_fields cyc %0d: addr=%h we=%b wd=%h to=%b expected port_d=%b addr=%h we=%b wd=%h to=%b",
                                 g, cyc, mem_addr, mem_we, mem_wdata, tmo, cur_d,
                                 cur_d ? d_addr : i_addr, cur_d ? d_we : 1'b0, d_wdata, exp_to);
                     end
                     busy = 1; cnt = 0;
                     r    = $urandom_range(0, 9);
                     lat  = hang_all ? 999 : (r <= 5) ? r : (r == 6) ? TO : (r == 7) ? 999 : r - 7;
                  end
               end
               if (busy) begin
                  fin = 0;
                  if (cnt == lat) begin
                     mem_ack = 1'b1;
                     sb.push_back({cur_d, mem_data});
                     fin = 1;
                  end else if (cnt == TO) begin
                     sb.push_back({cur_d, {DW{1'b0}}});
                     exp_to = 1;
                     fin = 1;
                  end
                  if (fin) begin
                     busy = 0; last_done = cyc;
                     if (cur_d) done_d = cyc; else done_i = cyc;
                  end else begin
                     cnt++;
                  end
               end
            end
         end
      end

      // Scoreboard monitor: an ack is expected exactly in cycles where the
      // reference pushed an entry.
      initial begin : monitor
         logic [DW:0] e;
         forever begin
            @(negedge clk);
            if (sb.size() > 0 || i_ack || d_ack) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL g%0d unexpected_ack: i_ack=%b d_ack=%b expected none", g, i_ack, d_ack);
               end else begin
                  e = sb.pop_front();
                  if ({d_ack, i_ack} !== (e[DW] ? 2'b10 : 2'b01) ||
                      (e[DW] ? d_data : i_data) !== e[DW-1:0]) begin
                     errors++;
                     $display("FAIL g%0d ack_route: d_ack=%b i_ack=%b data=%h expected port_d=%b data=%h",
                              g, d_ack, i_ack, e[DW] ? d_data : i_data, e[DW], e[DW-1:0]);
                  end
               end
            end
         end
      end

      initial begin : stim
         int t;
         rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; hang_all = 0;
         i_addr = '0; d_addr = '0; d_wdata = '0;
         @(negedge clk);
         checks++;
         if ({mem_req, mem_we, i_ack, d_ack, tmo} !== 5'b0 || mem_addr !== '0 ||
             mem_wdata !== '0 || i_data !== '0 || d_data !== '0) begin
            errors++;
            $display("FAIL g%0d reset_state: req=%b we=%b ia=%b da=%b to=%b addr=%h wd=%h expected all 0",
                     g, mem_req, mem_we, i_ack, d_ack, tmo, mem_addr, mem_wdata);
         end
         @(negedge clk);
         rst_n = 1'b1;
         fork
            begin
               for (int n = 0; n < NTX; n++) begin
                  int w;
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #2;
                  i_addr = AW'($urandom);
                  i_req  = 1'b1;
                  w = 0;
                  @(negedge clk);
                  while (!i_ack && w < 40) begin @(negedge clk); w++; end
                  checks++;
                  if (!i_ack) begin
                     errors++;
                     $display("FAIL g%0d wait_i_ack: i_ack=%b after %0d cycles, expected 1", g, i_ack, w);
                  end
                  repeat ($urandom_range(1, 2)) @(posedge clk);
                  #2 i_req = 1'b0;
               end
            end
            begin
               for (int n = 0; n < NTX; n++) begin
                  int w;
                  repeat ($urandom_range(0, 3)) @(posedge clk);
                  #2;
                  d_addr  = AW'($urandom);
                  d_wdata = $urandom;
                  d_we    = 1'($urandom_range(0, 1));
                  d_req   = 1'b1;
                  w = 0;
                  @(negedge clk);
                  while (!d_ack && w < 40) begin @(negedge clk); w++; end
                  checks++;
                  if (!d_ack) begin
                     errors++;
                     $display("FAIL g%0d wait_d_ack: d_ack=%b after %0d cycles, expected 1", g, d_ack, w);
                  end
                  repeat ($urandom_range(1, 2)) @(posedge clk);
                  #2 d_req = 1'b0;
               end
            end
         join

         // Reset in the middle of a hanging data read.
         repeat (4) @(posedge clk);
         #2;
         hang_all = 1;
         d_addr = AW'(30'h2A0); d_we = 1'b0; d_req = 1'b1;
         t = 0;
         @(negedge clk);
         while (!mem_req && t < 10) begin @(negedge clk); t++; end
         checks++;
         if (!mem_req) begin
            errors++;
            $display("FAIL g%0d rst_setup: mem_req=%b expected 1", g, mem_req);
         end
         repeat (2) @(posedge clk);
         #3 rst_n = 1'b0;
         #1;
         checks++;
         if ({mem_req, i_ack, d_ack, tmo} !== 4'b0) begin
            errors++;
            $display("FAIL g%0d rst_async: req=%b ia=%b da=%b to=%b expected 0",
                     g, mem_req, i_ack, d_ack, tmo);
         end
         d_req = 1'b0;
         hang_all = 0;
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk);
         #2;
         i_addr = AW'(30'h100);
         i_req  = 1'b1;
         t = 0;
         @(negedge clk);
         while (!i_ack && t < 40) begin @(negedge clk); t++; end
         checks++;
         if (!i_ack) begin
            errors++;
            $display("FAIL g%0d post_rst_ack: i_ack=%b expected 1", g, i_ack);
         end
         @(posedge clk);
         #2 i_req = 1'b0;
         repeat (6) @(posedge clk);
         @(negedge clk);
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL g%0d sb_drain: %0d pending expected 0", g, sb.size());
         end
         done_g[g] = 1'b1;
      end
   end

   initial begin : top
      for (int c = 0; c < 20000 && !(done_g[0] && done_g[1]); c++) @(posedge clk);
      if (!(done_g[0] && done_g[1])) begin
         errors++;
         $display("FAIL global_timeout: done=%b%b expected 11", done_g[1], done_g[0]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
